// File: rtl/multi_canal_sec_if.sv
// Channel bank / sample-output bundle for multi_canal_sec.
// Optional oParidad member present only when MULTI_PARIDAD_EN is defined.
interface multi_canal_sec_if #(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) ();
  logic [CHANNELS*WIDTH-1:0] iData;
  logic [SEL_W-1:0]          iSelector;
  logic                      iMode;
  logic                      iEnable;
  logic                      iReady;
  logic [WIDTH-1:0]          oSalida;
  logic [SEL_W-1:0]          oCanal;
  logic                      oValid;
`ifdef MULTI_PARIDAD_EN
  logic                      oParidad;
`endif

  // Source/consumer side: drives channels and controls, takes samples.
  modport master (
    output iData, iSelector, iMode, iEnable, iReady,
`ifdef MULTI_PARIDAD_EN
    input  oParidad,
`endif
    input  oSalida, oCanal, oValid
  );

  // Multiplexer side.
  modport slave (
    input  iData, iSelector, iMode, iEnable, iReady,
`ifdef MULTI_PARIDAD_EN
    output oParidad,
`endif
    output oSalida, oCanal, oValid
  );
endinterface

// File: rtl/multi_canal_sec.sv
// Registered N-channel multiplexer with manual/round-robin scan modes and a
// valid/ready output. Define MULTI_PARIDAD_EN to add the oParidad output.
module multi_canal_sec #(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 8,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int DWELL    = 4
) (
  input  logic             iClk,
  input  logic             iReset_n,
  multi_canal_sec_if.slave bus
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MANUAL, S_SCAN} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] salida_q, salida_d;
  logic [SEL_W-1:0] canal_q, canal_d;
  logic             valid_q, valid_d;
  logic             paridad_q, paridad_d;

  logic [WIDTH-1:0] chan [CHANNELS];
  logic [SEL_W-1:0] sel_idx;
  logic [SEL_W-1:0] cap_idx;
  logic [WIDTH-1:0] cap_data;
  logic             capture;
  logic             stall;

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      chan[k] = bus.iData[k*WIDTH +: WIDTH];
    end
  end

  // Out-of-range selects fall onto the last channel.
  assign sel_idx = (32'(bus.iSelector) >= CHANNELS) ? SEL_W'(CHANNELS - 1) : bus.iSelector;
  assign stall   = valid_q && !bus.iReady;

  // NOTE: every variable gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    cap_idx = ptr_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.iEnable) begin
          if (bus.iMode) begin
            state_d = S_SCAN;
            ptr_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d = S_MANUAL;
          end
        end
      end

      S_MANUAL: begin
        if (!bus.iEnable) begin
          state_d = S_IDLE;
        end else begin
          capture = !stall;
          cap_idx = sel_idx;
          if (bus.iMode) begin
            state_d = S_SCAN;
            ptr_d   = '0;
            cnt_d   = '0;
          end
        end
      end

      S_SCAN: begin
        if (!bus.iEnable) begin
          state_d = S_IDLE;
        end else begin
          if (cnt_q == CNT_W'(DWELL - 1)) begin
            // A stalled dwell end parks the counter until the consumer drains.
            if (!stall) begin
              capture = 1'b1;
              cap_idx = ptr_q;
              ptr_d   = (32'(ptr_q) == CHANNELS - 1) ? '0 : ptr_q + 1'b1;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          if (!bus.iMode) state_d = S_MANUAL;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign cap_data = chan[cap_idx];

  always_comb begin
    salida_d  = salida_q;
    canal_d   = canal_q;
    valid_d   = valid_q;
    paridad_d = paridad_q;
    if (capture) begin
      salida_d  = cap_data;
      canal_d   = cap_idx;
      valid_d   = 1'b1;
      paridad_d = ^cap_data;
    end else if (valid_q && bus.iReady) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      salida_q  <= '0;
      canal_q   <= '0;
      valid_q   <= 1'b0;
      paridad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      salida_q  <= salida_d;
      canal_q   <= canal_d;
      valid_q   <= valid_d;
      paridad_q <= paridad_d;
    end
  end

  assign bus.oSalida = salida_q;
  assign bus.oCanal  = canal_q;
  assign bus.oValid  = valid_q;
`ifdef MULTI_PARIDAD_EN
  assign bus.oParidad = paridad_q;
`else
  logic unused_paridad;
  assign unused_paridad = paridad_q;
`endif

endmodule

// File: tb/tb_multi_canal_sec.sv
// Directed self-checking bench for multi_canal_sec: an 8-channel DWELL=3
// instance for manual/scan/stall/reset and a 6-channel one for range clamping.
module tb_multi_canal_sec;

  logic clk;
  logic rst_n;

  int n_cmp = 0;
  int n_err = 0;

  multi_canal_sec_if #(.CHANNELS(8), .WIDTH(8)) a_if ();
  multi_canal_sec_if #(.CHANNELS(6), .WIDTH(8)) b_if ();

  multi_canal_sec #(.CHANNELS(8), .WIDTH(8), .DWELL(3)) dut_a (
    .iClk     (clk),
    .iReset_n (rst_n),
    .bus      (a_if.slave)
  );

  multi_canal_sec #(.CHANNELS(6), .WIDTH(8), .DWELL(2)) dut_b (
    .iClk     (clk),
    .iReset_n (rst_n),
    .bus      (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge; outputs are read and inputs changed 1 time unit later.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_a(input string tag, input int data, input int canal, input int valid);
    check({tag, ".salida"}, 32'(a_if.oSalida), 32'(data));
    check({tag, ".canal"},  32'(a_if.oCanal),  32'(canal));
    check({tag, ".valid"},  32'(a_if.oValid),  32'(valid));
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 8; k++) a_if.iData[k*8 +: 8] = 8'(8'h10 + k);
    for (int k = 0; k < 6; k++) b_if.iData[k*8 +: 8] = 8'(8'h20 + k);
    a_if.iSelector = '0;
    a_if.iMode     = 1'b0;
    a_if.iEnable   = 1'b0;
    a_if.iReady    = 1'b1;
    b_if.iSelector = 3'd7;
    b_if.iMode     = 1'b0;
    b_if.iEnable   = 1'b1;
    b_if.iReady    = 1'b1;

    step(2);
    check_a("reset", 0, 0, 0);
    rst_n = 1'b1;
    step(1);
    check_a("idle_disabled", 0, 0, 0);

    // Manual sweep: first edge only moves IDLE->MANUAL.
    a_if.iEnable = 1'b1;
    step(1);
    check("manual_entry.valid", 32'(a_if.oValid), 0);
    for (int s = 0; s < 8; s++) begin
      a_if.iSelector = 3'(s);
      step(1);
      check_a($sformatf("manual_sel%0d", s), 8'h10 + s, s, 1);
    end

    // Range clamp on the 6-channel instance (running manual since release).
    check("clamp_sel7.canal",  32'(b_if.oCanal),  5);
    check("clamp_sel7.salida", 32'(b_if.oSalida), 32'h25);
    b_if.iSelector = 3'd6;
    step(1);
    check("clamp_sel6.canal", 32'(b_if.oCanal), 5);
    b_if.iSelector = 3'd4;
    step(1);
    check("inrange_sel4.canal",  32'(b_if.oCanal),  4);
    check("inrange_sel4.salida", 32'(b_if.oSalida), 32'h24);

    // Switch to scan: the switching edge still captures manual selector 7.
    a_if.iSelector = 3'd7;
    a_if.iMode     = 1'b1;
    step(1);
    check_a("scan_entry", 8'h17, 7, 1);
    for (int i = 0; i < 9; i++) begin
      step(2);
      check($sformatf("scan%0d_gap.valid", i), 32'(a_if.oValid), 0);
      step(1);
      check_a($sformatf("scan%0d", i), 8'h10 + (i % 8), i % 8, 1);
    end

    // Stall right after the wrap capture of channel 0.
    a_if.iReady = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check_a($sformatf("stall%0d", i), 8'h10, 0, 1);
    end
    a_if.iReady = 1'b1;
    step(1);
    check_a("stall_release", 8'h11, 1, 1);

    // Advance to ptr=4 (captures of channels 2 and 3).
    step(3);
    check_a("scan_ch2", 8'h12, 2, 1);
    step(3);
    check_a("scan_ch3", 8'h13, 3, 1);

    // Mode switch mid-scan to manual channel 2.
    a_if.iMode     = 1'b0;
    a_if.iSelector = 3'd2;
    step(1);
    check("to_manual.valid", 32'(a_if.oValid), 0);
    step(1);
    check_a("to_manual_ch2", 8'h12, 2, 1);

    // Back to scan restarts at channel 0.
    a_if.iMode = 1'b1;
    step(1);
    step(3);
    check_a("rescan_ch0", 8'h10, 0, 1);

    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check_a("async_reset", 0, 0, 0);
    step(1);
    a_if.iMode = 1'b0;
    a_if.iSelector = 3'd0;
    a_if.iData[7:0]  = 8'h07;
    a_if.iData[15:8] = 8'h03;
    rst_n = 1'b1;
    step(1);
    check("post_reset_entry.valid", 32'(a_if.oValid), 0);
    step(1);
    check_a("post_reset_ch0", 8'h07, 0, 1);
`ifdef MULTI_PARIDAD_EN
    check("paridad_07", 32'(a_if.oParidad), 1);
`endif
    a_if.iSelector = 3'd1;
    step(1);
    check_a("post_reset_ch1", 8'h03, 1, 1);
`ifdef MULTI_PARIDAD_EN
    check("paridad_03", 32'(a_if.oParidad), 0);
`endif

    // Leaving MANUAL keeps the pending sample until a handshake.
    a_if.iEnable = 1'b0;
    a_if.iReady  = 1'b0;
    step(1);
    check_a("disable_hold", 8'h03, 1, 1);
    a_if.iReady = 1'b1;
    step(1);
    check("disable_drain.valid", 32'(a_if.oValid), 0);
    step(2);
    check("idle_no_capture.valid", 32'(a_if.oValid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_canal_sec.md
# multi_canal_sec

Parametrised, registered N-channel multiplexer with a valid/ready output handshake. It extends the 4:1 bit selector to W-bit channels, any channel count, and an automatic round-robin scan mode with a programmable dwell time. It sits between a bank of parallel sources (sensor registers, switch banks, counters) and a single downstream consumer that samples one channel at a time.

## Interface
- CHANNELS, 8: number of input channels, ≥2
- WIDTH, 8: bits per channel, ≥1
- SEL_W, $clog2(CHANNELS): selector/channel-index width
- DWELL, 4: cycles spent on each channel in scan mode, ≥1

- iClk  in  1  clock, all state on rising edge
- iReset_n  in  1  asynchronous, active-low reset
- iData  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- iSelector  in  SEL_W  channel select in manual mode
- iMode  in  1  0 = manual, 1 = scan
- iEnable  in  1  1 = block produces samples; 0 = no new samples
- iReady  in  1  consumer accepts oSalida this cycle
- oSalida  out  WIDTH  registered sample
- oCanal  out  SEL_W  channel index of the current oSalida
- oValid  out  1  oSalida/oCanal hold an unconsumed sample

## Operation
- Out-of-range select (iSelector ≥ CHANNELS) maps to channel CHANNELS-1.
- Stall = oValid && !iReady. While stalled, oSalida, oCanal and oValid are frozen. No sample is lost or overwritten.
- FSM states:
  - IDLE
    - No capture.
    - iEnable=1 and iMode=0 → MANUAL.
    - iEnable=1 and iMode=1 → SCAN. Entry clears the scan pointer and the dwell counter to 0.
  - MANUAL
    - Captures the channel selected by iSelector every non-stalled cycle.
    - iMode=1 → SCAN, with the pointer and counter cleared.
    - iEnable=0 → IDLE.
  - SCAN
    - The dwell counter counts 0..DWELL-1.
    - At DWELL-1 with no stall: capture channel ptr, then ptr ← ptr+1 (wraps CHANNELS-1 → 0), counter ← 0.
    - At DWELL-1 while stalled: the counter holds at DWELL-1 and the capture waits.
    - iMode=0 → MANUAL.
    - iEnable=0 → IDLE.
- The next state is evaluated in the same cycle as capture. No capture happens on the cycle iEnable is sampled low.
- Leaving MANUAL or SCAN does not clear a pending oValid. It stays high until a handshake completes.
- A handshake (oValid && iReady) with no capture in the same cycle → oValid ← 0.
- A handshake and a capture in the same cycle → new data, oValid stays 1 (back-to-back throughput).

## Timing
- Reset values: oSalida=0, oCanal=0, oValid=0, FSM=IDLE, ptr=0, dwell counter=0.
- Reset asserted mid-operation clears all state immediately and asynchronously. The first capture after release needs iEnable sampled high, then one IDLE→MANUAL/SCAN transition.
- Manual latency:
  - iSelector/iData sampled at edge N appear on oSalida after edge N. No combinational input→output path.
  - First sample: cycle after entering MANUAL.
- Scan:
  - After entering SCAN, the first capture (channel 0) occurs at the DWELL-th edge.
  - Unstalled: one sample per DWELL cycles.
  - Full sweep: CHANNELS*DWELL cycles.
- DWELL=1: capture every cycle, pointer advances every cycle.

## Configuration
- MULTI_PARIDAD_EN defined:
  - Adds output oParidad (1 bit), the even parity (XOR) of the captured channel data.
  - Registered with oSalida, same reset value 0, frozen on stall.
- Not defined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Manual, CHANNELS=8, WIDTH=8, channel k = 8'h10+k, iReady=1. Step iSelector 0..7 → oSalida 10..17 one cycle later, oCanal matches, oValid=1 continuously.
- Out-of-range, CHANNELS=6, iSelector=7 → oCanal=5, oSalida=channel 5 data.
- Scan, DWELL=3, iReady=1 → captures every 3 cycles on channels 0,1,…,7,0. Wrap to 0 at the 9th sample.
- Stall: scan with iReady=0 for 10 cycles after the first capture → oSalida/oValid frozen, pointer stays at 1. Raise iReady → channel 1 captured on the next non-stalled dwell end.
- Mode switch mid-scan at ptr=4 to manual with iSelector=2 → next sample is channel 2. Return to scan → restarts at channel 0.
- Async reset asserted mid-scan while oValid=1 → all outputs 0 immediately, without a clock. With MULTI_PARIDAD_EN: data 8'h07 gives oParidad=1, 8'h03 gives 0.
